jtcop_sndrom_arb: RTL and testbench



---
 rtl/jtcop_snd_pkg.sv | 7 +
 rtl/jtcop_sndrom_slot.sv | 35 +++
 rtl/jtcop_sndrom_arb.sv | 76 +++++++
 tb/tb_jtcop_sndrom_arb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/jtcop_snd_pkg.sv
// jtcop_snd_pkg: shared FSM state encoding and default SDRAM word offsets for the sound ROM arbiter.
package jtcop_snd_pkg;
  typedef logic [1:0] st_t;
  localparam st_t IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;
  localparam logic [21:0] SND_OFFSET_DEF = 22'h0;
  localparam logic [21:0] PCM_OFFSET_DEF = 22'h10000;
endpackage

// File: rtl/jtcop_sndrom_slot.sv
// jtcop_sndrom_slot: one-word cache for a single requester with tag compare, byte select and registered ok.
module jtcop_sndrom_slot (
  input  logic        clk24,
  input  logic        rst24,
  input  logic        cs,
  input  logic        sel,
  input  logic [21:0] waddr,
  input  logic        fill,
  input  logic [21:0] fill_addr,
  input  logic [15:0] fill_data,
  output logic        hit,
  output logic [7:0]  data,
  output logic        ok
);
  logic        valid;
  logic [21:0] tag;
  logic [15:0] word;
  assign hit = valid && tag == waddr;
  always_ff @(posedge clk24 or posedge rst24)
    if (rst24) begin
      valid <= 1'b0;
      tag   <= '0;
      word  <= '0;
      data  <= '0;
      ok    <= 1'b0;
    end else begin
      if (fill) begin
        valid <= 1'b1;
        tag   <= fill_addr;
        word  <= fill_data;
      end
      ok   <= cs && hit;
      data <= sel ? word[15:8] : word[7:0];
    end
endmodule

// File: rtl/jtcop_sndrom_arb.sv
// jtcop_sndrom_arb: arbitrates sound CPU and ADPCM ROM reads onto one SDRAM bank.
// Define JTCOP_SNDROM_RR_EN for round-robin tie breaking; otherwise the sound CPU wins ties.
module jtcop_sndrom_arb
  import jtcop_snd_pkg::*;
#(
  parameter logic [21:0] SND_OFFSET = SND_OFFSET_DEF,
  parameter logic [21:0] PCM_OFFSET = PCM_OFFSET_DEF
) (
  input  logic        clk24,
  input  logic        rst24,
  input  logic        snd_cs,
  input  logic        snd_bank,
  input  logic [15:0] snd_addr,
  output logic [7:0]  snd_data,
  output logic        snd_ok,
  input  logic        adpcm_cs,
  input  logic [17:0] adpcm_addr,
  output logic [7:0]  adpcm_data,
  output logic        adpcm_ok,
  output logic [21:0] ba_addr,
  output logic        ba_rd,
  input  logic        ba_ack,
  input  logic        ba_rdy,
  input  logic [15:0] data_read
);
  st_t         st;
  logic        win, pick, done, snd_hit, pcm_hit, snd_pend, pcm_pend;
  logic [21:0] snd_wa, pcm_wa;
  assign snd_wa   = SND_OFFSET + {5'd0, snd_bank, snd_addr[15:1]};
  assign pcm_wa   = PCM_OFFSET + {5'd0, adpcm_addr[17:1]};
  assign snd_pend = snd_cs && !snd_hit;
  assign pcm_pend = adpcm_cs && !pcm_hit;
  assign done     = (st == REQ && ba_ack && ba_rdy) || (st == WAIT && ba_rdy);
`ifdef JTCOP_SNDROM_RR_EN
  logic prio_pcm;
  assign pick = pcm_pend && (!snd_pend || prio_pcm);
`else
  assign pick = pcm_pend && !snd_pend;
`endif
  always_ff @(posedge clk24 or posedge rst24)
    if (rst24) begin
      st      <= IDLE;
      ba_rd   <= 1'b0;
      ba_addr <= '0;
      win     <= 1'b0;
`ifdef JTCOP_SNDROM_RR_EN
      prio_pcm <= 1'b0;
`endif
    end else if (st == IDLE) begin
      if (snd_pend || pcm_pend) begin
        ba_addr <= pick ? pcm_wa : snd_wa;
        ba_rd   <= 1'b1;
        win     <= pick;
        st      <= REQ;
`ifdef JTCOP_SNDROM_RR_EN
        prio_pcm <= !pick;
`endif
      end
    end else if (st == REQ) begin
      if (ba_ack) begin
        ba_rd <= 1'b0;
        st    <= ba_rdy ? IDLE : WAIT;
      end
    end else
      st <= (st == WAIT && !ba_rdy) ? WAIT : IDLE;
  jtcop_sndrom_slot u_snd (
    .clk24(clk24), .rst24(rst24), .cs(snd_cs), .sel(snd_addr[0]), .waddr(snd_wa),
    .fill(done && !win), .fill_addr(ba_addr), .fill_data(data_read),
    .hit(snd_hit), .data(snd_data), .ok(snd_ok)
  );
  jtcop_sndrom_slot u_pcm (
    .clk24(clk24), .rst24(rst24), .cs(adpcm_cs), .sel(adpcm_addr[0]), .waddr(pcm_wa),
    .fill(done && win), .fill_addr(ba_addr), .fill_data(data_read),
    .hit(pcm_hit), .data(adpcm_data), .ok(adpcm_ok)
  );
endmodule

// File: tb/tb_jtcop_sndrom_arb.sv
// tb_jtcop_sndrom_arb: directed vectors with a scoreboard of expected SDRAM addresses and returned bytes.
module tb_jtcop_sndrom_arb;
  logic        clk24 = 0, rst24 = 1, snd_cs = 0, snd_bank = 0, adpcm_cs = 0, ba_ack = 0, ba_rdy = 0;
  logic [15:0] snd_addr = 0, data_read = 0;
  logic [17:0] adpcm_addr = 0;
  logic [7:0]  snd_data, adpcm_data;
  logic        snd_ok, adpcm_ok, ba_rd;
  logic [21:0] ba_addr;
  int          nvec = 0, nerr = 0, ack_dly = 2, rdy_dly = 3;
  bit          same = 0;
  logic [21:0] exp_addr[$];
  logic [7:0]  exp_snd[$], exp_pcm[$];

  always #5 clk24 = ~clk24;

  jtcop_sndrom_arb dut (
    .clk24(clk24), .rst24(rst24), .snd_cs(snd_cs), .snd_bank(snd_bank), .snd_addr(snd_addr),
    .snd_data(snd_data), .snd_ok(snd_ok), .adpcm_cs(adpcm_cs), .adpcm_addr(adpcm_addr),
    .adpcm_data(adpcm_data), .adpcm_ok(adpcm_ok), .ba_addr(ba_addr), .ba_rd(ba_rd),
    .ba_ack(ba_ack), .ba_rdy(ba_rdy), .data_read(data_read)
  );

  function automatic logic [15:0] mem(input logic [21:0] a);
    return a == 22'h1 ? 16'hA55A : a[15:0] ^ 16'h1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk24);
      #2;
    end
  endtask

  task automatic wait_sig(input string name, input int which, input logic lvl);
    int i;
    logic v;
    i = 0;
    forever begin
      v = which == 0 ? snd_ok : which == 1 ? adpcm_ok : ba_rd;
      if (v === lvl) break;
      if (i == 60) begin
        nvec++;
        nerr++;
        $display("FAIL %s: timeout, signal still %b, required %b", name, v, lvl);
        break;
      end
      i++;
      tick();
    end
  endtask

  // SDRAM model: ack after ack_dly, data after rdy_dly (or together when same is set)
  initial forever begin
    @(negedge clk24);
    if (ba_rd === 1'b1) begin
      repeat (ack_dly) @(negedge clk24);
      if (ba_rd === 1'b1) begin
        ba_ack    = 1;
        data_read = mem(ba_addr);
        ba_rdy    = same;
        @(negedge clk24);
        ba_ack = 0;
        ba_rdy = 0;
        if (!same) begin
          repeat (rdy_dly) @(negedge clk24);
          ba_rdy = 1;
          @(negedge clk24);
          ba_rdy = 0;
        end
      end
    end
  end

  initial begin : monitor
    logic       rd_q, sok_q, pok_q;
    logic [7:0] sd_q, pd_q;
    rd_q = 0; sok_q = 0; pok_q = 0; sd_q = 0; pd_q = 0;
    forever begin
      @(negedge clk24);
      if (ba_rd === 1'b1 && !rd_q) begin
        if (exp_addr.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL ba_rd: unexpected request at %h, none required", ba_addr);
        end else chk("ba_addr", ba_addr, exp_addr.pop_front());
      end
      if (snd_ok === 1'b1 && (!sok_q || snd_data !== sd_q)) begin
        if (exp_snd.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL snd_data: unexpected ok with %h, none required", snd_data);
        end else chk("snd_data", snd_data, exp_snd.pop_front());
      end
      if (adpcm_ok === 1'b1 && (!pok_q || adpcm_data !== pd_q)) begin
        if (exp_pcm.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL adpcm_data: unexpected ok with %h, none required", adpcm_data);
        end else chk("adpcm_data", adpcm_data, exp_pcm.pop_front());
      end
      rd_q  = ba_rd === 1'b1;
      sok_q = snd_ok === 1'b1;
      pok_q = adpcm_ok === 1'b1;
      sd_q  = snd_data;
      pd_q  = adpcm_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(2);
    chk("rst ba_rd", ba_rd, 0);
    chk("rst ba_addr", ba_addr, 0);
    chk("rst snd_ok", snd_ok, 0);
    chk("rst adpcm_ok", adpcm_ok, 0);
    chk("rst snd_data", snd_data, 0);
    chk("rst adpcm_data", adpcm_data, 0);
    rst24 = 0;
    tick();
    // sound miss, odd byte of word 1
    exp_addr.push_back(22'h1); exp_snd.push_back(8'hA5);
    snd_addr = 16'h0003; snd_cs = 1;
    wait_sig("snd miss ok", 0, 1);
    // hit on the even byte of the same word
    exp_snd.push_back(8'h5A);
    snd_addr = 16'h0002;
    tick();
    chk("hit ok", snd_ok, 1);
    tick(2);
    snd_cs = 0;
    tick(2);
    // two ties: sound is served first each time
    exp_addr.push_back(22'h8080); exp_addr.push_back(22'h10100);
    exp_snd.push_back(8'hB4); exp_pcm.push_back(8'h34);
    snd_bank = 1; snd_addr = 16'h0100; adpcm_addr = 18'h200;
    snd_cs = 1; adpcm_cs = 1;
    wait_sig("tie1 snd ok", 0, 1);
    wait_sig("tie1 adpcm ok", 1, 1);
    snd_cs = 0; adpcm_cs = 0;
    tick(2);
    exp_addr.push_back(22'h8); exp_addr.push_back(22'h10018);
    exp_snd.push_back(8'h3C); exp_pcm.push_back(8'h2C);
    snd_bank = 0; snd_addr = 16'h0010; adpcm_addr = 18'h30;
    snd_cs = 1; adpcm_cs = 1;
    wait_sig("tie2 snd ok", 0, 1);
    wait_sig("tie2 adpcm ok", 1, 1);
    snd_cs = 0; adpcm_cs = 0;
    tick(2);
    // abort: cs drops while waiting for data
    ack_dly = 1; rdy_dly = 4;
    exp_addr.push_back(22'h10);
    snd_addr = 16'h0020; snd_cs = 1;
    wait_sig("abort ba_rd rise", 2, 1);
    wait_sig("abort ba_rd fall", 2, 0);
    snd_cs = 0;
    tick(8);
    chk("abort ok", snd_ok, 0);
    exp_snd.push_back(8'h24);
    snd_cs = 1;
    tick();
    chk("refill hit ok", snd_ok, 1);
    tick();
    snd_cs = 0;
    tick(2);
    // ack and rdy together, top of the ADPCM range
    ack_dly = 2; same = 1;
    exp_addr.push_back(22'h2FFFF); exp_pcm.push_back(8'hED);
    adpcm_addr = 18'h3FFFF; adpcm_cs = 1;
    wait_sig("offset adpcm ok", 1, 1);
    same = 0;
    tick();
    // reset while a sound request is in REQ
    ack_dly = 6;
    exp_addr.push_back(22'h20);
    snd_addr = 16'h0040; snd_cs = 1;
    wait_sig("rst ba_rd rise", 2, 1);
    tick();
    exp_addr.push_back(22'h20); exp_addr.push_back(22'h2FFFF);
    exp_snd.push_back(8'h14); exp_pcm.push_back(8'hED);
    rst24 = 1;
    #1;
    chk("midrst ba_rd", ba_rd, 0);
    chk("midrst snd_ok", snd_ok, 0);
    chk("midrst adpcm_ok", adpcm_ok, 0);
    tick();
    rst24 = 0;
    wait_sig("post rst snd ok", 0, 1);
    wait_sig("post rst adpcm ok", 1, 1);
    snd_cs = 0; adpcm_cs = 0;
    tick(10);
    chk("addr queue left", exp_addr.size(), 0);
    chk("snd queue left", exp_snd.size(), 0);
    chk("adpcm queue left", exp_pcm.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
